// File: rtl/cls_pkg.sv
// Shared types and default timing for the CLS fault recovery sequencer.
package cls_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    FATAL  = 2'd3
  } cls_rec_state_e;

  localparam int unsigned DEF_RST_HOLD_CYCLES = 8;
  localparam int unsigned DEF_SETTLE_CYCLES   = 2;
  localparam int unsigned DEF_MAX_RETRIES     = 3;
  localparam int unsigned DEF_WINDOW_CYCLES   = 1024;

  // Counter width for a limit; never below one bit so a limit of 1 still elaborates.
  function automatic int unsigned cnt_w(input int unsigned lim);
    return (lim < 2) ? 1 : $clog2(lim);
  endfunction

endpackage

// File: rtl/cls_fault_recovery_ctrl_if.sv
// Fault/recovery signal bundle between the lockstep comparator side and the sequencer.
interface cls_fault_recovery_ctrl_if #(parameter int FAULT_CNT_W = 8);
  logic                   fault_i;
  logic                   clear_fatal_i;
  logic                   core_rst_no;
  logic                   cmp_mask_o;
  logic                   fault_ack_o;
  logic                   recovering_o;
  logic                   fatal_o;
  logic [FAULT_CNT_W-1:0] fault_count_o;

  modport master (
    output fault_i, clear_fatal_i,
    input  core_rst_no, cmp_mask_o, fault_ack_o, recovering_o, fatal_o, fault_count_o
  );

  modport slave (
    input  fault_i, clear_fatal_i,
    output core_rst_no, cmp_mask_o, fault_ack_o, recovering_o, fatal_o, fault_count_o
  );
endinterface

// File: rtl/cls_cycle_timer.sv
// Loadable up-counter with clear; tc flags the cycle on which the count equals last.
module cls_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         tc
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (load)   cnt <= load_val;
    else if (en)     cnt <= cnt + W'(1);
  end

  assign tc = (cnt == last);
endmodule

// File: rtl/cls_fault_recovery_ctrl.sv
// CLS recovery sequencer: reset hold, comparator settle mask, retry window and latched FATAL.
module cls_fault_recovery_ctrl
  import cls_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
  parameter int unsigned MAX_RETRIES     = DEF_MAX_RETRIES,
  parameter int unsigned WINDOW_CYCLES   = DEF_WINDOW_CYCLES,
  parameter int unsigned FAULT_CNT_W     = 8
) (
  input logic                       clk,
  input logic                       rst,
  cls_fault_recovery_ctrl_if.slave  bus
);
  localparam int PW = (cnt_w(RST_HOLD_CYCLES) > cnt_w(SETTLE_CYCLES)) ?
                      cnt_w(RST_HOLD_CYCLES) : cnt_w(SETTLE_CYCLES);
  localparam int WW = cnt_w(WINDOW_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 2);

  localparam logic [PW-1:0] HOLD_LAST   = PW'(RST_HOLD_CYCLES - 1);
  localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
  localparam logic [WW-1:0] WIN_LAST    = WW'(WINDOW_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

  if (RST_HOLD_CYCLES < 1) begin : g_bad_hold
    $error("RST_HOLD_CYCLES must be >= 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end
  if (WINDOW_CYCLES < 2) begin : g_bad_window
    $error("WINDOW_CYCLES must be >= 2");
  end
  if (FAULT_CNT_W < 1) begin : g_bad_cnt_w
    $error("FAULT_CNT_W must be >= 1");
  end

  cls_rec_state_e         state, next_state;
  logic [RW-1:0]          retry_cnt, retry_nxt;
  logic [FAULT_CNT_W-1:0] fault_cnt;
  logic                   phase_clr, phase_en, phase_tc;
  logic                   win_clr, win_en, win_tc;
  logic                   accept;
  logic [PW-1:0]          phase_last;

  // One timer serves both HOLD and SETTLE; it is cleared on every phase exit.
  assign phase_last = (state == HOLD) ? HOLD_LAST : SETTLE_LAST;

  cls_cycle_timer #(.W(PW)) u_phase_tmr (
    .clk(clk), .rst(rst), .clr(phase_clr), .load(1'b0), .load_val('0),
    .en(phase_en), .last(phase_last), .tc(phase_tc)
  );

  cls_cycle_timer #(.W(WW)) u_win_tmr (
    .clk(clk), .rst(rst), .clr(win_clr), .load(1'b0), .load_val('0),
    .en(win_en), .last(WIN_LAST), .tc(win_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= HOLD;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    retry_nxt  = retry_cnt;
    phase_clr  = 1'b0;
    phase_en   = 1'b0;
    win_clr    = 1'b1;
    win_en     = 1'b0;
    accept     = 1'b0;
    unique case (state)
      HOLD: begin
        phase_en = 1'b1;
        if (phase_tc) begin
          next_state = SETTLE;
          phase_clr  = 1'b1;
        end
      end
      SETTLE: begin
        phase_en = 1'b1;
        if (phase_tc) begin
          next_state = RUN;
          phase_clr  = 1'b1;
        end
      end
      RUN: begin
        phase_clr = 1'b1;
        // A fault on the expiry cycle wins and is judged against the old retry count.
        if (bus.fault_i) begin
          accept = 1'b1;
          if (retry_cnt == RETRY_MAX) begin
            next_state = FATAL;
          end else begin
            next_state = HOLD;
            retry_nxt  = retry_cnt + RW'(1);
          end
        end else if (win_tc) begin
          retry_nxt = '0;
        end else begin
          win_clr = 1'b0;
          win_en  = 1'b1;
        end
      end
      FATAL: begin
        phase_clr = 1'b1;
        if (bus.clear_fatal_i) begin
          next_state = HOLD;
          retry_nxt  = '0;
        end
      end
      default: next_state = HOLD;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt        <= '0;
      fault_cnt        <= '0;
      bus.core_rst_no  <= 1'b0;
      bus.cmp_mask_o   <= 1'b1;
      bus.recovering_o <= 1'b1;
      bus.fatal_o      <= 1'b0;
      bus.fault_ack_o  <= 1'b0;
    end else begin
      retry_cnt        <= retry_nxt;
      if (accept && (fault_cnt != '1)) fault_cnt <= fault_cnt + FAULT_CNT_W'(1);
      bus.core_rst_no  <= (next_state == SETTLE) || (next_state == RUN);
      bus.cmp_mask_o   <= (next_state != RUN);
      bus.recovering_o <= (next_state == HOLD) || (next_state == SETTLE);
      bus.fatal_o      <= (next_state == FATAL);
      bus.fault_ack_o  <= accept;
    end
  end

  assign bus.fault_count_o = fault_cnt;
endmodule

// File: tb/tb_cls_fault_recovery_ctrl.sv
// Scoreboard bench: stimulus queues expected per-cycle outputs and acks, a negedge monitor compares.
module tb_cls_fault_recovery_ctrl;
  typedef struct {
    int         cyc;
    bit         sel;
    logic [4:0] fl;   // {core_rst_no, cmp_mask_o, recovering_o, fatal_o, fault_ack_o}
    int         cnt;
    string      nm;
  } chk_t;

  typedef struct {
    int cnt;
    bit ft;
  } ack_t;

  localparam logic [4:0] F_HOLD     = 5'b01100;
  localparam logic [4:0] F_HOLD_ACK = 5'b01101;
  localparam logic [4:0] F_SETTLE   = 5'b11100;
  localparam logic [4:0] F_RUN      = 5'b10000;
  localparam logic [4:0] F_FAT_ACK  = 5'b01011;
  localparam logic [4:0] F_FATAL    = 5'b01010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ecnt, run_at, t, c, p;

  chk_t chk_q[$];
  ack_t ack_q[$];

  cls_fault_recovery_ctrl_if #(.FAULT_CNT_W(8)) ifa ();
  cls_fault_recovery_ctrl_if #(.FAULT_CNT_W(2)) ifb ();

  cls_fault_recovery_ctrl #(
    .RST_HOLD_CYCLES(8), .SETTLE_CYCLES(2), .MAX_RETRIES(3),
    .WINDOW_CYCLES(1024), .FAULT_CNT_W(8)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  cls_fault_recovery_ctrl #(
    .RST_HOLD_CYCLES(8), .SETTLE_CYCLES(2), .MAX_RETRIES(10),
    .WINDOW_CYCLES(1024), .FAULT_CNT_W(2)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", nm, cyc, act, expv);
    end
  endtask

  task automatic push_chk(input chk_t e);
    int i;
    i = chk_q.size();
    while (i > 0 && chk_q[i-1].cyc > e.cyc) i--;
    chk_q.insert(i, e);
  endtask

  task automatic exp_a(input int cy, input logic [4:0] fl, input int cnt, input string nm);
    chk_t e;
    e.cyc = cy; e.sel = 1'b0; e.fl = fl; e.cnt = cnt; e.nm = nm;
    push_chk(e);
  endtask

  task automatic exp_b(input int cy, input logic [4:0] fl, input int cnt, input string nm);
    chk_t e;
    e.cyc = cy; e.sel = 1'b1; e.fl = fl; e.cnt = cnt; e.nm = nm;
    push_chk(e);
  endtask

  task automatic push_ack(input int cnt, input bit ft);
    ack_t a;
    a.cnt = cnt; a.ft = ft;
    ack_q.push_back(a);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int cy);
    if (cy > cyc) step(cy - cyc);
  endtask

  // Power-on sequence starting at cycle pc (the first cycle with rst low).
  task automatic power_on(input int pc);
    exp_a(pc,      F_HOLD,   0, "rst_state");
    exp_a(pc + 7,  F_HOLD,   0, "po_hold_last");
    exp_a(pc + 8,  F_SETTLE, 0, "po_settle_first");
    exp_a(pc + 9,  F_SETTLE, 0, "po_settle_last");
    exp_a(pc + 10, F_RUN,    0, "po_run_first");
    run_at = pc + 10;
  endtask

  task automatic fault_a(input bit fatal);
    t = cyc;
    ecnt = (ecnt < 255) ? ecnt + 1 : 255;
    push_ack(ecnt, fatal);
    if (!fatal) begin
      exp_a(t + 1,  F_HOLD_ACK, ecnt, "flt_hold_entry");
      exp_a(t + 8,  F_HOLD,     ecnt, "flt_hold_last");
      exp_a(t + 9,  F_SETTLE,   ecnt, "flt_settle_first");
      exp_a(t + 10, F_SETTLE,   ecnt, "flt_settle_last");
      exp_a(t + 11, F_RUN,      ecnt, "flt_run_reentry");
      run_at = t + 11;
    end else begin
      exp_a(t + 1, F_FAT_ACK, ecnt, "flt_fatal_entry");
    end
    ifa.fault_i = 1'b1;
    step(1);
    ifa.fault_i = 1'b0;
  endtask

  task automatic clear_fatal_a();
    c = cyc;
    exp_a(c,      F_FATAL,  ecnt, "clr_before");
    exp_a(c + 1,  F_HOLD,   ecnt, "clr_hold_entry");
    exp_a(c + 8,  F_HOLD,   ecnt, "clr_hold_last");
    exp_a(c + 9,  F_SETTLE, ecnt, "clr_settle");
    exp_a(c + 11, F_RUN,    ecnt, "clr_run");
    run_at = c + 11;
    ifa.clear_fatal_i = 1'b1;
    step(1);
    ifa.clear_fatal_i = 1'b0;
  endtask

  // Monitor: pops the ack scoreboard on every ack, and the timed scoreboard when due.
  ack_t ae;
  chk_t ce;
  logic [4:0] af;
  int ac;
  always @(negedge clk) begin
    if (ifa.fault_ack_o === 1'b1) begin
      if (ack_q.size() == 0) check("ack_unexpected", 1, 0);
      else begin
        ae = ack_q.pop_front();
        check("ack_count", int'(ifa.fault_count_o), ae.cnt);
        check("ack_fatal", int'(ifa.fatal_o), int'(ae.ft));
      end
    end
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      ce = chk_q.pop_front();
      if (ce.cyc < cyc) check({ce.nm, "_missed"}, cyc, ce.cyc);
      else begin
        if (ce.sel) begin
          af = {ifb.core_rst_no, ifb.cmp_mask_o, ifb.recovering_o, ifb.fatal_o, ifb.fault_ack_o};
          ac = int'(ifb.fault_count_o);
        end else begin
          af = {ifa.core_rst_no, ifa.cmp_mask_o, ifa.recovering_o, ifa.fatal_o, ifa.fault_ack_o};
          ac = int'(ifa.fault_count_o);
        end
        check({ce.nm, "_flags"}, int'(af), int'(ce.fl));
        check({ce.nm, "_cnt"}, ac, ce.cnt);
      end
    end
  end

  initial begin
    ifa.fault_i = 1'b0; ifa.clear_fatal_i = 1'b0;
    ifb.fault_i = 1'b1; ifb.clear_fatal_i = 1'b0;
    ecnt = 0;

    // Power-on with defaults
    step(3);
    rst = 1'b0;
    p = cyc;
    power_on(p);

    // dut_b: fault stuck high, accepted on each first RUN cycle, count saturates at 3
    for (int k = 1; k <= 11; k++)
      exp_b(p + 11 * k, (k < 11) ? F_HOLD_ACK : F_FAT_ACK, (k < 3) ? k : 3, "b_stuck_ack");
    exp_b(p + 300, F_FATAL, 3, "b_fatal_hold");

    // clear_fatal_i has no effect in RUN, then a single fault
    step_to(p + 15);
    exp_a(p + 16, F_RUN, 0, "clr_ignored_run");
    ifa.clear_fatal_i = 1'b1;
    step(1);
    ifa.clear_fatal_i = 1'b0;
    step_to(p + 20);
    fault_a(1'b0);

    // Ten faults, each 1100 RUN cycles apart: the window always clears the retry count
    for (int i = 0; i < 10; i++) begin
      step_to(run_at + 1100);
      fault_a(1'b0);
    end

    // Retry count to 3, then fault on the exact window-expiry cycle
    for (int i = 0; i < 2; i++) begin
      step_to(run_at + 20);
      fault_a(1'b0);
    end
    step_to(run_at + 1023);
    fault_a(1'b1);
    c = cyc;
    exp_a(c + 100, F_FATAL, ecnt, "fatal_ignores_fault");
    exp_a(c + 499, F_FATAL, ecnt, "fatal_hold");
    step_to(c + 99);
    ifa.fault_i = 1'b1;
    step(1);
    ifa.fault_i = 1'b0;
    step_to(c + 500);
    clear_fatal_a();

    // Four quick faults: the fourth goes FATAL and holds; then clear
    for (int i = 0; i < 3; i++) begin
      step_to(run_at + 20);
      fault_a(1'b0);
    end
    step_to(run_at + 20);
    fault_a(1'b1);
    exp_a(cyc + 499, F_FATAL, ecnt, "fatal_hold_500");
    step(500);
    clear_fatal_a();

    // fault_i stuck high on dut_a: first acceptance after clear is not fatal, fourth is
    step_to(run_at + 20);
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      ecnt++;
      push_ack(ecnt, k == 3);
      exp_a(t + 11 * k + 1, (k < 3) ? F_HOLD_ACK : F_FAT_ACK, ecnt, "stuck_ack");
    end
    exp_a(t + 9, F_SETTLE, ecnt - 3, "stuck_settle_ignored");
    ifa.fault_i = 1'b1;
    step_to(t + 40);
    ifa.fault_i = 1'b0;

    // rst for one cycle in FATAL, then again mid-HOLD; power-on repeats
    ecnt = 0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_a(cyc, F_HOLD, 0, "rst_from_fatal");
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    power_on(cyc);
    step_to(run_at + 20);
    fault_a(1'b0);
    step(20);

    check("chk_q_drained", chk_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cls_fault_recovery_ctrl.md
Name: cls_fault_recovery_ctrl

Overview:
Recovery sequencer for the core-level-lockstep (CLS) cluster. It consumes the mismatch `fault_i` pulse from the lockstep comparator and drives the shared active-low core reset. It also masks the comparator while the cores come out of reset. Repeated faults inside a time window escalate to a latched fatal state that holds the cores in reset until software or the system clears it.

Parameters:
RST_HOLD_CYCLES, 8, cycles `core_rst_no` is held low per reset sequence (>=1)
SETTLE_CYCLES, 2, cycles after reset release during which the comparator stays masked (>=1)
MAX_RETRIES, 3, faults tolerated inside one window; fault number MAX_RETRIES+1 goes FATAL (>=0)
WINDOW_CYCLES, 1024, fault-free RUN cycles after which the retry count clears (>=2)
FAULT_CNT_W, 8, width of the lifetime fault counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
fault_i  in  1  comparator mismatch, sampled only in RUN
clear_fatal_i  in  1  leaves FATAL; single-cycle pulse
core_rst_no  out  1  active-low reset to all three cores
cmp_mask_o  out  1  1 = comparator must ignore mismatches
fault_ack_o  out  1  1-cycle pulse per accepted fault
recovering_o  out  1  1 while in HOLD or SETTLE
fatal_o  out  1  1 while in FATAL
fault_count_o  out  FAULT_CNT_W  saturating lifetime count of accepted faults

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered.
- While `rst` is high:
  - state=HOLD, all counters 0, `fault_count_o`=0
  - `core_rst_no`=0, `cmp_mask_o`=1, `recovering_o`=1, `fault_ack_o`=0, `fatal_o`=0
- HOLD:
  - `core_rst_no`=0, `cmp_mask_o`=1.
  - Stays exactly RST_HOLD_CYCLES cycles, then goes to SETTLE.
  - `fault_i` is ignored.
- SETTLE:
  - `core_rst_no`=1, `cmp_mask_o`=1.
  - Stays exactly SETTLE_CYCLES cycles, then goes to RUN with the window counter at 0.
  - `fault_i` is ignored.
- RUN:
  - `core_rst_no`=1, `cmp_mask_o`=0.
  - The window counter increments each cycle. When it reaches WINDOW_CYCLES-1 with no fault, `retry_cnt` clears to 0 and the window counter wraps to 0.
- Fault accepted in RUN (`fault_i`=1 at cycle t):
  - At t+1: `fault_ack_o`=1 for that cycle only.
  - `fault_count_o` increments, saturating at all-ones; it never wraps.
  - The window counter clears.
  - If old `retry_cnt` == MAX_RETRIES: FATAL, `retry_cnt` unchanged.
  - Otherwise: `retry_cnt`+1 and HOLD. `core_rst_no`=0 from t+1 through t+RST_HOLD_CYCLES; `cmp_mask_o` returns to 0 at t+RST_HOLD_CYCLES+SETTLE_CYCLES+1.
- Fault in the same cycle as window expiry: the fault wins. It counts against the un-cleared `retry_cnt`.
- FATAL:
  - `core_rst_no`=0, `cmp_mask_o`=1, `fatal_o`=1, `recovering_o`=0.
  - `fault_i` is ignored.
  - `clear_fatal_i`=1 → HOLD next cycle with `retry_cnt`=0. `fault_count_o` is retained.
  - `clear_fatal_i` is ignored in every other state.
- `rst` mid-sequence (any state, including FATAL): the next cycle is the reset condition above, then a full power-on sequence starts.
- Widths: the hold, settle and window counters are each `$clog2` of their limit. `retry_cnt` is `$clog2(MAX_RETRIES+2)` bits wide. Comparisons are unsigned.
- Illegal parameter values are caught by elaboration-time assertions.

Decomposition:
- Shared package `cls_pkg`:
  - `cls_rec_state_e` enum: HOLD, SETTLE, RUN, FATAL
  - default constants for the four timing parameters
- Sub-module `cls_cycle_timer`: loadable up-counter with clear and a terminal-count flag. It is instantiated for the hold/settle timing (reloaded per state) and for the window timing.
- The FSM and the saturating counters stay in the top module.

Test Plan:
1. Power-on, defaults. `rst` high 3 cycles, then low at cycle 0 → `core_rst_no`=0 for cycles 0..7, 1 from cycle 8. `cmp_mask_o`=0 from cycle 10. `recovering_o` falls with it. All other outputs 0.
2. Single fault in RUN at cycle t → at t+1 `fault_ack_o`=1 (t+1 only) and `fault_count_o`=1. `core_rst_no`=0 for t+1..t+8. `cmp_mask_o`=0 again at t+11.
3. Four faults, each ~20 cycles after RUN re-entry → the 4th gives `fatal_o`=1 and `core_rst_no` stays 0 for 500 cycles. `fault_count_o`=4. A `clear_fatal_i` pulse leads to a normal 8+2 recovery; the next fault then does not go FATAL.
4. Ten faults, each 1100 RUN cycles apart → never FATAL, `fault_count_o`=10. Variant: fault exactly on window-expiry cycle with `retry_cnt`=3 → FATAL.
5. `fault_i` held high permanently → ignored in HOLD/SETTLE. It is re-accepted on the first RUN cycle of each recovery and reaches FATAL on the 4th acceptance. With FAULT_CNT_W=2 and MAX_RETRIES=10, `fault_count_o` stops at 3.
6. `rst` asserted for 1 cycle mid-HOLD and again in FATAL → next cycle `fatal_o`=0 and `fault_count_o`=0. The power-on sequence of scenario 1 then repeats exactly.
